// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and constants for the FIFO read-side packer.
package fifo_rd_packer_pkg;

   // state | meaning
   // WAIT  | post-reset hold-off, rreq forced low while FIFO flags settle
   // RUN   | normal popping and packing, held until reset
   typedef enum logic {
      WAIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int STARTUP_CYCLES = 2;
   localparam int STARTUP_W      = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

endpackage

// File: rtl/fifo_rd_packer_out.sv
// Single-entry output register with valid/ready handshake (fifo_out_slice).
// A load in the same cycle as a transfer replaces the accepted word.
module fifo_out_slice #(
   parameter int W = 32,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] ld_data,
   input  logic [K-1:0] ld_keep,
   input  logic         m_ready,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   output logic [K-1:0] m_keep
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic [K-1:0] keep_q, keep_d;

   // next-state: load wins, otherwise hold until the word is accepted
   always_comb begin
      valid_d = load | (valid_q & ~m_ready);
      data_d  = load ? ld_data : data_q;
      keep_d  = load ? ld_keep : keep_q;
   end

   // output word registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign m_keep  = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops DSIZE-bit entries and packs RATIO of them,
// little-endian, into one wide word on a valid/ready master port.
// Optional partial-word flush after TIMEOUT idle cycles is enabled by
// defining FIFO_RD_PACKER_TIMEOUT_EN.
//
// state | meaning
// WAIT  | STARTUP_CYCLES after reset with rreq low (rempty not yet valid)
// RUN   | popping whenever the completed word would have somewhere to go
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter int DSIZE   = 8,
   parameter int RATIO   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   rclk,
   input  logic                   rrst,
   input  logic                   rempty,
   input  logic [DSIZE-1:0]       rdata,
   output logic                   rreq,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DSIZE*RATIO-1:0] m_data,
   output logic [RATIO-1:0]       m_keep
);

   localparam int              CW       = $clog2(RATIO);
   localparam int              WW       = DSIZE * RATIO;
   localparam logic [CW-1:0]   CNT_LAST = CW'(RATIO - 1);

   state_e                 state_q, state_d;
   logic [STARTUP_W-1:0]   startup_q, startup_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WW-1:0]          pack_q, pack_d;
   logic [WW-1:0]          pack_word;
   logic [RATIO-1:0]       partial_keep;
   logic                   last;
   logic                   pop;
   logic                   flush;
   logic                   load;
   logic [WW-1:0]          ld_data;
   logic [RATIO-1:0]       ld_keep;

   // FSM next-state: count out the startup hold-off, then stay in RUN
   always_comb begin
      state_d   = state_q;
      startup_d = startup_q;
      if (state_q == WAIT) begin
         if (startup_q == STARTUP_W'(STARTUP_CYCLES - 1)) begin
            state_d = RUN;
         end else begin
            startup_d = startup_q + STARTUP_W'(1);
         end
      end
   end

   // FSM state registers
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q   <= WAIT;
         startup_q <= '0;
      end else begin
         state_q   <= state_d;
         startup_q <= startup_d;
      end
   end

   // rreq depends only on registered state and m_ready, never on rempty
   assign last = (cnt_q == CNT_LAST);
   assign rreq = (state_q == RUN) & ~(last & m_valid & ~m_ready);
   assign pop  = rreq & ~rempty;

   // current pack register with the FIFO head merged into lane cnt
   always_comb begin
      pack_word = pack_q;
      for (int i = 0; i < RATIO; i++) begin
         if (cnt_q == CW'(i)) begin
            pack_word[i*DSIZE +: DSIZE] = rdata;
         end
      end
   end

   // lanes below cnt hold data in a partial word
   always_comb begin
      partial_keep = '0;
      for (int i = 0; i < RATIO; i++) begin
         partial_keep[i] = (i < int'(cnt_q));
      end
   end

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);

   logic [IW-1:0] idle_q, idle_d;

   // flush waits for the output register to be free or draining this cycle
   assign flush = ~pop & (cnt_q != '0) & (idle_q == IW'(TIMEOUT)) & (~m_valid | m_ready);

   // idle counter: counts stalled cycles of a partial word, saturates at TIMEOUT
   always_comb begin
      idle_d = idle_q;
      if (pop || flush || (cnt_q == '0)) begin
         idle_d = '0;
      end else if (idle_q != IW'(TIMEOUT)) begin
         idle_d = idle_q + IW'(1);
      end
   end

   // idle counter register
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout;

   assign flush          = 1'b0;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   // packing: a completing pop or a flush hands the word to the output slice
   always_comb begin
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      load    = 1'b0;
      ld_data = pack_word;
      ld_keep = '1;
      if (pop) begin
         if (last) begin
            load    = 1'b1;
            ld_data = pack_word;
            ld_keep = '1;
            pack_d  = '0;
            cnt_d   = '0;
         end else begin
            pack_d = pack_word;
            cnt_d  = cnt_q + CW'(1);
         end
      end else if (flush) begin
         load    = 1'b1;
         ld_data = pack_q;
         ld_keep = partial_keep;
         pack_d  = '0;
         cnt_d   = '0;
      end
   end

   // pack register and lane counter; cleared after each hand-off so unused
   // lanes of a flushed word read as zero
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt_q  <= '0;
         pack_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pack_q <= pack_d;
      end
   end

   fifo_out_slice #(
      .W (WW),
      .K (RATIO)
   ) u_out (
      .clk     (rclk),
      .rst     (rrst),
      .load    (load),
      .ld_data (ld_data),
      .ld_keep (ld_keep),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_keep  (m_keep)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a small show-ahead FIFO model feeds
// the DUT, directed tests push expected words, a monitor checks transfers.
module tb_fifo_rd_packer;

   localparam int DSIZE   = 8;
   localparam int RATIO   = 4;
   localparam int TIMEOUT = 16;
   localparam int WW      = DSIZE * RATIO;

   typedef struct packed {
      logic [WW-1:0]    data;
      logic [RATIO-1:0] keep;
   } word_t;

   logic             rclk = 1'b0;
   logic             rrst = 1'b1;
   logic             rempty = 1'b1;
   logic [DSIZE-1:0] rdata = '0;
   logic             rreq;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WW-1:0]    m_data;
   logic [RATIO-1:0] m_keep;

   int               checks = 0;
   int               errors = 0;
   int               pops = 0;
   logic             pop_now = 1'b0;
   logic             gate = 1'b0;
   logic             toggle_en = 1'b0;
   logic [DSIZE-1:0] fifo_q[$];
   word_t            exp_q[$];
   word_t            mon_w;
   int               base;

   always #5 rclk = ~rclk;

   fifo_rd_packer #(
      .DSIZE   (DSIZE),
      .RATIO   (RATIO),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rempty  (rempty),
      .rdata   (rdata),
      .rreq    (rreq),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_keep  (m_keep)
   );

   // FIFO model: sample the pop mid-cycle, retire it just after the edge
   always @(negedge rclk) pop_now = rreq & ~rempty;

   always @(posedge rclk) begin
      #1;
      if (pop_now) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pops++;
      end
      pop_now = 1'b0;
      gate    = toggle_en ? ~gate : 1'b0;
      rempty  = gate | (fifo_q.size() == 0);
      rdata   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   // monitor: every transfer is compared against the next expected word
   always @(negedge rclk) begin
      if (!rrst && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word actual=%08h/%01h required=none", m_data, m_keep);
         end else begin
            mon_w = exp_q.pop_front();
            if (m_data !== mon_w.data || m_keep !== mon_w.keep) begin
               errors++;
               $display("FAIL word actual=%08h/%01h required=%08h/%01h",
                        m_data, m_keep, mon_w.data, mon_w.keep);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge rclk);
         #2;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      fifo_q.push_back(a);
      fifo_q.push_back(b);
      fifo_q.push_back(c);
      fifo_q.push_back(d);
   endtask

   task automatic expect_word(input logic [WW-1:0] d, input logic [RATIO-1:0] k);
      word_t w;
      w.data = d;
      w.keep = k;
      exp_q.push_back(w);
   endtask

   task automatic wait_pops(input int target, input int limit);
      int n = 0;
      while (pops < target && n < limit) begin
         tick();
         n++;
      end
      chk("wait_pops", pops, target);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < limit) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset values and startup hold-off
      rrst    = 1'b1;
      m_ready = 1'b1;
      push4(8'h11, 8'h12, 8'h13, 8'h14);
      expect_word(32'h14131211, 4'hF);
      tick(3);
      chk("rst_rreq", rreq, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_keep", m_keep, 0);
      rrst = 1'b0;
      chk("startup_c1_rreq", rreq, 0);
      tick();
      chk("startup_c2_rreq", rreq, 0);
      tick();
      chk("startup_c3_rreq", rreq, 1);
      chk("startup_no_pop", pops, 0);
      tick();
      chk("first_pop_c3", pops, 1);
      drain(50);

      // back-to-back word and output latency
      base = pops;
      push4(8'h01, 8'h02, 8'h03, 8'h04);
      expect_word(32'h04030201, 4'hF);
      tick(4);
      chk("t2_pops3", pops, base + 3);
      chk("t2_valid_before", m_valid, 0);
      tick();
      chk("t2_pops4", pops, base + 4);
      chk("t2_valid_after", m_valid, 1);
      chk("t2_data_direct", m_data, 32'h04030201);
      drain(50);

      // backpressure: rreq stalls at the last lane while output is full
      m_ready = 1'b0;
      base = pops;
      push4(8'h21, 8'h22, 8'h23, 8'h24);
      push4(8'h25, 8'h26, 8'h27, 8'h28);
      push4(8'h29, 8'h2A, 8'h2B, 8'h2C);
      expect_word(32'h24232221, 4'hF);
      expect_word(32'h28272625, 4'hF);
      expect_word(32'h2C2B2A29, 4'hF);
      tick(12);
      chk("t3_stall_pops", pops, base + 7);
      chk("t3_stall_rreq", rreq, 0);
      chk("t3_stall_valid", m_valid, 1);
      chk("t3_stall_data", m_data, 32'h24232221);
      chk("t3_fifo_left7", fifo_q.size(), 5);
      m_ready = 1'b1;
      tick();
      chk("t3_resume_pops", pops, base + 8);
      chk("t3_fifo_left8", fifo_q.size(), 4);
      drain(50);

      // rempty toggling: no loss or duplication
      toggle_en = 1'b1;
      base = pops;
      push4(8'h01, 8'h02, 8'h03, 8'h04);
      push4(8'h05, 8'h06, 8'h07, 8'h08);
      expect_word(32'h04030201, 4'hF);
      expect_word(32'h08070605, 4'hF);
      wait_pops(base + 8, 60);
      drain(50);
      toggle_en = 1'b0;
      tick(2);

      // partial word: flushed after idling, or held until completed
      base = pops;
      fifo_q.push_back(8'h0A);
      fifo_q.push_back(8'h0B);
      fifo_q.push_back(8'h0C);
      wait_pops(base + 3, 20);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
      expect_word(32'h000C0B0A, 4'h7);
      tick(15);
      chk("t5_no_early_flush", m_valid, 0);
      drain(10);
`else
      tick(30);
      chk("t5_partial_held", m_valid, 0);
      fifo_q.push_back(8'h0D);
      expect_word(32'h0D0C0B0A, 4'hF);
      drain(50);
`endif

      // reset mid-word discards partial and pending output words
      m_ready = 1'b0;
      base = pops;
      push4(8'h31, 8'h32, 8'h33, 8'h34);
      fifo_q.push_back(8'h35);
      fifo_q.push_back(8'h36);
      wait_pops(base + 6, 30);
      chk("t6_pending_valid", m_valid, 1);
      rrst = 1'b1;
      tick();
      chk("t6_rst_valid", m_valid, 0);
      chk("t6_rst_keep", m_keep, 0);
      chk("t6_rst_data", m_data, 0);
      chk("t6_rst_rreq", rreq, 0);
      rrst    = 1'b0;
      m_ready = 1'b1;
      push4(8'h41, 8'h42, 8'h43, 8'h44);
      expect_word(32'h44434241, 4'hF);
      drain(50);

      chk("final_exp_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
